// File: rtl/demux_7_router_pkg.sv
// Shared definitions for the 1-to-7 route demultiplexer: lane count, route FSM
// encoding and select normalisation.
package demux_7_router_pkg;

  localparam int unsigned NumLanes = 7;
  localparam int unsigned SelW     = 3;

  typedef logic [1:0] state_t;

  localparam state_t StRun    = 2'd0;
  localparam state_t StDrain  = 2'd1;
  localparam state_t StSwitch = 2'd2;

  // Select code 7 has no lane of its own; it aliases onto the last lane.
  function automatic logic [SelW-1:0] norm_lane(input logic [SelW-1:0] sel);
    return (sel == 3'd7) ? 3'd6 : sel;
  endfunction

endpackage

// File: rtl/stream_reg_1.sv
// One-entry valid/ready pipeline register with full-throughput pass-through:
// a beat may be accepted in the same cycle the held beat drains.
module stream_reg_1 #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [Width-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic             full_q, full_d;
  logic [Width-1:0] data_q, data_d;
  logic             in_fire;

  assign in_ready_o  = !full_q || out_ready_i;
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_valid_o = full_q;
  assign out_data_o  = data_q;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (in_fire) begin
      full_d = 1'b1;
      data_d = in_data_i;
    end else if (out_ready_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/demux_7_router.sv
// Steers one valid/ready stream onto one of seven lanes; route changes wait for
// the buffered beat to drain so nothing is lost or sent down the wrong lane.
module demux_7_router
  import demux_7_router_pkg::*;
#(
  parameter int unsigned Width = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [Width-1:0]    din_i,
  input  logic                din_valid_i,
  output logic                din_ready_o,
  output logic [Width-1:0]    dout_o,
  output logic [NumLanes-1:0] dout_valid_o,
  input  logic [NumLanes-1:0] dout_ready_i,
  input  logic [SelW-1:0]     cfg_sel_i,
  input  logic                cfg_req_i,
  output logic                cfg_ack_o,
  output logic [SelW-1:0]     cur_sel_o
);

  state_t                state_q, state_d;
  logic [SelW-1:0]       sel_q, sel_d;
  logic [SelW-1:0]       pend_q, pend_d;
  logic [SelW-1:0]       sel_n;
  logic                  run;
  logic                  lane_ready;
  logic                  reg_in_ready;
  logic                  reg_full;
  logic [NumLanes-1:0]   lane_onehot;

  assign run        = (state_q == StRun);
  assign sel_n      = norm_lane(cfg_sel_i);
  assign lane_ready = dout_ready_i[sel_q];

  stream_reg_1 #(
    .Width (Width)
  ) u_out_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data_i   (din_i),
    .in_valid_i  (din_valid_i && run),
    .in_ready_o  (reg_in_ready),
    .out_data_o  (dout_o),
    .out_valid_o (reg_full),
    .out_ready_i (lane_ready)
  );

  always_comb begin
    lane_onehot        = '0;
    lane_onehot[sel_q] = 1'b1;
  end

  assign dout_valid_o = reg_full ? lane_onehot : '0;
  assign din_ready_o  = run && reg_in_ready;
  assign cfg_ack_o    = (state_q == StSwitch);
  assign cur_sel_o    = sel_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pend_d  = pend_q;
    unique case (state_q)
      StRun: begin
        // A beat accepted alongside the request still belongs to the old route.
        if (cfg_req_i) begin
          pend_d  = sel_n;
          state_d = (sel_n == sel_q) ? StSwitch : StDrain;
        end
      end
      StDrain: begin
        if (!reg_full) state_d = StSwitch;
      end
      StSwitch: begin
        sel_d   = pend_q;
        state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      sel_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_demux_7_router.sv
// Directed and randomized bench for demux_7_router against a transaction-level
// model of the buffered beat, the active lane and any pending route change.
module tb_demux_7_router;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:0] din_i;
  logic       din_valid_i;
  logic       din_ready_o;
  logic [0:0] dout_o;
  logic [6:0] dout_valid_o;
  logic [6:0] dout_ready_i;
  logic [2:0] cfg_sel_i;
  logic       cfg_req_i;
  logic       cfg_ack_o;
  logic [2:0] cur_sel_o;

  int errors = 0;
  int checks = 0;

  // Model: buffered beat, active lane, requested lane (-1 = none), switch cycle.
  bit   m_full;
  logic m_data;
  int   m_lane;
  int   m_pend;
  bit   m_sw;

  demux_7_router dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .din_i        (din_i),
    .din_valid_i  (din_valid_i),
    .din_ready_o  (din_ready_o),
    .dout_o       (dout_o),
    .dout_valid_o (dout_valid_o),
    .dout_ready_i (dout_ready_i),
    .cfg_sel_i    (cfg_sel_i),
    .cfg_req_i    (cfg_req_i),
    .cfg_ack_o    (cfg_ack_o),
    .cur_sel_o    (cur_sel_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_accepting(input logic [6:0] dr);
    return !m_sw && (m_pend < 0) && (!m_full || dr[m_lane]);
  endfunction

  task automatic model_reset();
    m_full = 1'b0;
    m_data = 1'b0;
    m_lane = 0;
    m_pend = -1;
    m_sw   = 1'b0;
  endtask

  task automatic check_outputs();
    logic [6:0] exp_valid;
    exp_valid = m_full ? (7'(1) << m_lane) : 7'd0;
    check("din_ready", 32'(din_ready_o), 32'(m_accepting(dout_ready_i)));
    check("dout_valid", 32'(dout_valid_o), 32'(exp_valid));
    check("dout", 32'(dout_o), 32'(m_data));
    check("cfg_ack", 32'(cfg_ack_o), 32'(m_sw));
    check("cur_sel", 32'(cur_sel_o), 32'(m_lane));
  endtask

  task automatic model_step(input logic d, input logic dv, input logic [6:0] dr,
                            input logic [2:0] cs, input logic cr);
    bit fire, take, idle_run;
    int want;
    fire     = dv && m_accepting(dr);
    take     = m_full && dr[m_lane];
    idle_run = !m_sw && (m_pend < 0);
    want     = (cs == 3'd7) ? 6 : int'(cs);
    if (m_sw) begin
      m_lane = m_pend;
      m_pend = -1;
      m_sw   = 1'b0;
    end else if (!idle_run) begin
      if (!m_full) m_sw = 1'b1;
    end else if (cr) begin
      m_pend = want;
      m_sw   = (want == m_lane);
    end
    if (fire) begin
      m_full = 1'b1;
      m_data = d;
    end else if (take) begin
      m_full = 1'b0;
    end
  endtask

  // Called one time unit after a rising edge; leaves the bench at the same phase.
  task automatic cycle(input logic d, input logic dv, input logic [6:0] dr,
                       input logic [2:0] cs, input logic cr);
    din_i        = d;
    din_valid_i  = dv;
    dout_ready_i = dr;
    cfg_sel_i    = cs;
    cfg_req_i    = cr;
    #1;
    check_outputs();
    @(posedge clk);
    model_step(d, dv, dr, cs, cr);
    #1;
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_dout_valid", 32'(dout_valid_o), 32'd0);
    check("rst_cfg_ack", 32'(cfg_ack_o), 32'd0);
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n        = 1'b0;
    din_i        = 1'b0;
    din_valid_i  = 1'b0;
    dout_ready_i = 7'h00;
    cfg_sel_i    = 3'd0;
    cfg_req_i    = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    // Streaming at full rate on lane 1.
    cycle(1'b1, 1'b1, 7'h7F, 3'd0, 1'b0);
    cycle(1'b0, 1'b1, 7'h7F, 3'd0, 1'b0);
    cycle(1'b1, 1'b1, 7'h7F, 3'd0, 1'b0);
    cycle(1'b0, 1'b0, 7'h7F, 3'd0, 1'b0);
    cycle(1'b0, 1'b0, 7'h7F, 3'd0, 1'b0);

    // Backpressure on lane 1 for three cycles, then resume.
    cycle(1'b1, 1'b1, 7'h7F, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 7'h7E, 3'd0, 1'b0);
    cycle(1'b0, 1'b1, 7'h7F, 3'd0, 1'b0);
    cycle(1'b1, 1'b1, 7'h7F, 3'd0, 1'b0);
    cycle(1'b0, 1'b0, 7'h7F, 3'd0, 1'b0);

    // Reconfigure to lane 5 with a beat stuck on lane 1.
    cycle(1'b1, 1'b1, 7'h7F, 3'd0, 1'b0);
    cycle(1'b0, 1'b0, 7'h7E, 3'd4, 1'b1);
    cycle(1'b0, 1'b0, 7'h7E, 3'd4, 1'b1);
    cycle(1'b0, 1'b1, 7'h7F, 3'd2, 1'b1);
    cycle(1'b0, 1'b1, 7'h7F, 3'd2, 1'b1);
    cycle(1'b0, 1'b1, 7'h7F, 3'd2, 1'b1);
    cycle(1'b1, 1'b1, 7'h7F, 3'd4, 1'b0);
    cycle(1'b0, 1'b0, 7'h7F, 3'd4, 1'b0);

    // Same-lane request: straight to the switch cycle.
    cycle(1'b0, 1'b1, 7'h7F, 3'd4, 1'b1);
    cycle(1'b0, 1'b1, 7'h7F, 3'd4, 1'b1);
    cycle(1'b0, 1'b0, 7'h7F, 3'd4, 1'b0);

    // Select code 7 aliases onto lane 7.
    cycle(1'b0, 1'b0, 7'h7F, 3'd7, 1'b1);
    cycle(1'b0, 1'b0, 7'h7F, 3'd7, 1'b1);
    cycle(1'b0, 1'b0, 7'h7F, 3'd7, 1'b1);
    cycle(1'b1, 1'b1, 7'h7F, 3'd7, 1'b0);
    cycle(1'b0, 1'b0, 7'h7F, 3'd7, 1'b0);

    // Reset while draining toward lane 4.
    cycle(1'b1, 1'b1, 7'h00, 3'd0, 1'b0);
    cycle(1'b0, 1'b0, 7'h00, 3'd3, 1'b1);
    cycle(1'b0, 1'b0, 7'h00, 3'd3, 1'b1);
    cycle(1'b0, 1'b0, 7'h00, 3'd3, 1'b1);
    async_reset();
    cycle(1'b0, 1'b1, 7'h7F, 3'd0, 1'b0);

    // Same-lane request on lane 1.
    cycle(1'b0, 1'b0, 7'h7F, 3'd0, 1'b1);
    cycle(1'b0, 1'b1, 7'h7F, 3'd0, 1'b1);
    cycle(1'b1, 1'b1, 7'h7F, 3'd0, 1'b0);

    // Randomized traffic, backpressure and route changes.
    for (int i = 0; i < 600; i++) begin
      logic [6:0] dr;
      dr = 7'($urandom);
      if ($urandom_range(0, 3) != 0) dr = dr | (7'(1) << m_lane);
      cycle(1'($urandom), 1'($urandom_range(0, 3) != 0), dr, 3'($urandom),
            $urandom_range(0, 7) == 0);
      if (i == 300) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
